// File: rtl/ram8_arbiter.sv
// Two-requester round-robin arbiter for a shared 8-word RAM.
// Each transaction takes three cycles: grant/ACCESS, RESP, then a done pulse while back in IDLE.
module ram8_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   owner;
  logic   last;
  logic   we_q;
  logic   pick_c;

  // Winner of the current IDLE arbitration; a tie goes to the requester not served last.
  always_comb begin
    pick_c = 1'b0;
    if (req0 && req1) pick_c = ~last;
    else if (req1)    pick_c = 1'b1;
  end

  // Transaction sequencer; RAM controls are registered so they line up with ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      we_q     <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      ram_load <= 1'b0;
      ram_addr <= '0;
      ram_in   <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state    <= ACCESS;
            owner    <= pick_c;
            gnt0     <= ~pick_c;
            gnt1     <= pick_c;
            ram_addr <= pick_c ? addr1 : addr0;
            ram_in   <= pick_c ? wdata1 : wdata0;
            ram_load <= pick_c ? we1 : we0;
            we_q     <= pick_c ? we1 : we0;
          end
        end
        ACCESS: begin
          ram_load <= 1'b0;
          state    <= RESP;
        end
        RESP: begin
          if (!we_q) begin
            if (owner) rdata1 <= ram_out;
            else       rdata0 <= ram_out;
          end
          done0    <= ~owner;
          done1    <= owner;
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          last     <= owner;
          ram_addr <= '0;
          ram_in   <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter with a behavioural 8x16 RAM model.
module tb_ram8_arbiter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, done0, done1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              ram_load;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out;

  logic [DATA_W-1:0] mem [8];
  logic              init_mem;

  int vectors = 0;
  int miscompares = 0;

  ram8_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_load(ram_load), .ram_addr(ram_addr), .ram_in(ram_in), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // Shared RAM: word i preloads to {4{i}}, e.g. word 4 = 16'h4444.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 8; i++) mem[i] <= {4{4'(i)}};
    end else if (ram_load) begin
      mem[ram_addr] <= ram_in;
    end
  end
  assign ram_out = mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_done0, n_done1, n_overlap, n_load;
  logic prev_g0, prev_g1;
  int order [$];

  initial begin
    reset = 1'b1; init_mem = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #2;
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_done", 32'({done0, done1}), 0);
    chk("rst_load", 32'(ram_load), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_in", 32'(ram_in), 0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 0);
    tick(); tick();
    reset = 1'b0; init_mem = 1'b0;

    // Single write then read by requester 0
    req0 = 1; we0 = 1; addr0 = 3'd5; wdata0 = 16'hBEEF;
    tick();
    chk("wr_gnt0", 32'(gnt0), 1);
    chk("wr_gnt1", 32'(gnt1), 0);
    chk("wr_load", 32'(ram_load), 1);
    chk("wr_addr", 32'(ram_addr), 5);
    chk("wr_in", 32'(ram_in), 32'hBEEF);
    tick();
    chk("wr_resp_load", 32'(ram_load), 0);
    chk("wr_resp_gnt0", 32'(gnt0), 1);
    chk("wr_mem5", 32'(mem[5]), 32'hBEEF);
    chk("wr_done0_early", 32'(done0), 0);
    tick();
    chk("wr_done0", 32'(done0), 1);
    chk("wr_gnt_off", 32'(gnt0), 0);
    chk("wr_idle_addr", 32'(ram_addr), 0);
    chk("wr_rdata0_keep", 32'(rdata0), 0);
    req0 = 0;
    tick();
    chk("wr_done0_pulse", 32'(done0), 0);
    req0 = 1; we0 = 0; addr0 = 3'd5;
    tick();
    chk("rd_load", 32'(ram_load), 0);
    chk("rd_addr", 32'(ram_addr), 5);
    tick();
    chk("rd_resp_addr", 32'(ram_addr), 5);
    tick();
    chk("rd_done0", 32'(done0), 1);
    chk("rd_rdata0", 32'(rdata0), 32'hBEEF);
    req0 = 0;
    tick();

    // Simultaneous reads after reset: requester 0 wins the first tie
    reset = 1; #1;
    chk("rst2_rdata0", 32'(rdata0), 0);
    tick(); reset = 0;
    req0 = 1; addr0 = 3'd1; we0 = 0;
    req1 = 1; addr1 = 3'd2; we1 = 0;
    tick();
    chk("sim_gnt", 32'({gnt0, gnt1}), 32'b10);
    chk("sim_addr0", 32'(ram_addr), 1);
    tick(); tick();
    chk("sim_done0", 32'({done0, done1}), 32'b10);
    chk("sim_rdata0", 32'(rdata0), 32'h1111);
    req0 = 0;
    tick();
    chk("sim_gnt1", 32'({gnt0, gnt1}), 32'b01);
    chk("sim_addr1", 32'(ram_addr), 2);
    tick(); tick();
    chk("sim_done1", 32'({done0, done1}), 32'b01);
    chk("sim_rdata1", 32'(rdata1), 32'h2222);
    chk("sim_rdata0_keep", 32'(rdata0), 32'h1111);
    req1 = 0;
    tick();

    // Fairness: both held for 12 cycles (last owner was 1)
    n_done0 = 0; n_done1 = 0; n_overlap = 0; n_load = 0;
    prev_g0 = 0; prev_g1 = 0;
    req0 = 1; req1 = 1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (gnt0 && !prev_g0) order.push_back(0);
      if (gnt1 && !prev_g1) order.push_back(1);
      prev_g0 = gnt0; prev_g1 = gnt1;
      if (gnt0 && gnt1) n_overlap++;
      if (done0 && done1) n_overlap++;
      if (ram_load) n_load++;
      n_done0 += int'(done0);
      n_done1 += int'(done1);
    end
    req0 = 0; req1 = 0;
    chk("fair_done0", 32'(n_done0), 2);
    chk("fair_done1", 32'(n_done1), 2);
    chk("fair_overlap", 32'(n_overlap), 0);
    chk("fair_load", 32'(n_load), 0);
    chk("fair_ngrants", 32'(order.size()), 4);
    if (order.size() == 4) begin
      chk("fair_order", 32'({order[0][0], order[1][0], order[2][0], order[3][0]}), 32'b0101);
    end
    tick();

    // Request dropped after grant still completes
    req1 = 1; we1 = 1; addr1 = 3'd7; wdata1 = 16'h1234;
    tick();
    chk("drop_gnt1", 32'(gnt1), 1);
    req1 = 0; wdata1 = 16'h0000; addr1 = 3'd0;
    tick();
    chk("drop_mem7", 32'(mem[7]), 32'h1234);
    tick();
    chk("drop_done1", 32'(done1), 1);
    chk("drop_rdata1_keep", 32'(rdata1), 32'h2222);
    tick();

    // Isolation: requester 1 write between two requester 0 reads of word 4
    req0 = 1; we0 = 0; addr0 = 3'd4;
    tick(); tick(); tick();
    chk("iso_rd1", 32'(rdata0), 32'h4444);
    req0 = 0;
    tick();
    req1 = 1; we1 = 1; addr1 = 3'd3; wdata1 = 16'h0C0C;
    tick();
    chk("iso_wr_load", 32'(ram_load), 1);
    tick();
    chk("iso_resp_load", 32'(ram_load), 0);
    tick();
    chk("iso_done1", 32'(done1), 1);
    chk("iso_rdata0", 32'(rdata0), 32'h4444);
    chk("iso_mem3", 32'(mem[3]), 32'h0C0C);
    req1 = 0;
    tick();
    req0 = 1;
    tick(); tick(); tick();
    chk("iso_rd2", 32'(rdata0), 32'h4444);
    req0 = 0;
    tick();

    // Reset during ACCESS of a write aborts it asynchronously
    req0 = 1; we0 = 1; addr0 = 3'd6; wdata0 = 16'hAAAA;
    tick();
    chk("abort_load_pre", 32'(ram_load), 1);
    #1 reset = 1; #1;
    chk("abort_load", 32'(ram_load), 0);
    chk("abort_gnt", 32'({gnt0, gnt1}), 0);
    chk("abort_mem6", 32'(mem[6]), 32'h6666);
    req0 = 0;
    tick();
    chk("abort_nodone", 32'({done0, done1}), 0);
    reset = 0;
    req0 = 1; we0 = 0; addr0 = 3'd1;
    req1 = 1; we1 = 0; addr1 = 3'd2;
    tick();
    chk("abort_tie_gnt", 32'({gnt0, gnt1}), 32'b10);
    tick(); tick();
    chk("abort_tie_done", 32'({done0, done1}), 32'b10);
    req0 = 0; req1 = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram8_arbiter.md
RAM8_ARBITER -- requirements
Module: ram8_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, word width of shared RAM and requester data paths.
REQ-002 Parameter: ADDR_W, 3, word address width (8 words).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0 / req1  input  1  transaction request from requester 0 / 1; held high until matching done.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; valid while req high.
REQ-007 addr0 / addr1  input  ADDR_W  word address; valid while req high.
REQ-008 wdata0 / wdata1  input  DATA_W  write data; valid while req high.
REQ-009 gnt0 / gnt1  output  1  high while requester owns the RAM (ACCESS and RESP states).
REQ-010 done0 / done1  output  1  one-cycle pulse marking transaction completion.
REQ-011 rdata0 / rdata1  output  DATA_W  registered read data; valid with done, held until that requester's next read completes.
REQ-012 ram_load  output  1  write enable to shared RAM.
REQ-013 ram_addr  output  ADDR_W  address to shared RAM.
REQ-014 ram_in  output  DATA_W  write data to shared RAM.
REQ-015 ram_out  input  DATA_W  combinational read data from shared RAM at ram_addr.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP; single owner register (0/1) and round-robin pointer last (0/1).
REQ-017 IDLE: no req -> stay IDLE; one req -> grant that requester; both req -> grant requester != last; granted -> ACCESS, owner latched.
REQ-018 ACCESS (exactly 1 cycle): ram_addr = addr of owner, ram_in = wdata of owner, ram_load = we of owner; -> RESP.
REQ-019 RESP (exactly 1 cycle): ram_load = 0, ram_addr held; on read, rdata of owner captures ram_out at end of RESP; done of owner pulses in cycle following RESP; last <= owner; -> IDLE.
REQ-020 Latency: req sampled high in IDLE at edge N -> done pulse during cycle N+3; write visible in RAM after ACCESS edge.
REQ-021 Throughput: at most one transaction per 3 cycles; continuous dual requests alternate 0,1,0,1.
REQ-022 gnt of owner high in ACCESS and RESP only; gnt0 and gnt1 never high together; done0 and done1 never high together.
REQ-023 ram_load high only in ACCESS and only when owner's we = 1; never high in IDLE or RESP.
REQ-024 req/we/addr/wdata sampled only in IDLE and ACCESS; dropping req after grant does not abort; transaction completes and done still pulses.
REQ-025 Requester keeping req high after done is treated as a new request in the next IDLE arbitration.
REQ-026 rdata of non-owner and rdata of owner on writes are unchanged.
REQ-027 ram_addr and ram_in drive 0 in IDLE.

Reset
REQ-028 reset high forces immediately (asynchronously): state IDLE, owner 0, last 1 (requester 0 wins first tie), all gnt/done/ram_load 0, ram_addr 0, ram_in 0, rdata0 = rdata1 = 0.
REQ-029 reset during ACCESS aborts the transaction: ram_load falls without waiting for clk; no done issued; RAM contents may already reflect a completed write edge only.
REQ-030 After reset deasserts, first arbitration occurs at the first rising edge with reset low.

Verification
REQ-031 Single write then read: req0, we0=1, addr0=5, wdata0=0xBEEF; then req0 read addr 5 -> ram_load high one cycle with ram_addr=5, ram_in=0xBEEF; done0 at N+3; rdata0=0xBEEF with second done0.
REQ-032 Simultaneous reads after reset: req0 addr 1, req1 addr 2, both held -> requester 0 served first, requester 1 next; done0 then done1 3 cycles apart; gnt never overlapping.
REQ-033 Fairness: req0 and req1 held high 12 cycles -> grant order 0,1,0,1; each gets 2 dones.
REQ-034 Request dropped after grant: req1 write addr 7 data 0x1234, req1 low in ACCESS -> write still performed, done1 still pulses.
REQ-035 Reset mid-transaction: assert reset in ACCESS of write -> ram_load, gnt drop asynchronously; no done; after release, req1 tie with req0 -> requester 0 granted.
REQ-036 Isolation: requester 1 write to addr 3 between two requester 0 reads of addr 4 -> rdata0 unaffected by requester 1 transaction; ram_load never high in RESP.
